ascon_wb_slave: RTL and testbench



---
 rtl/ascon_wb_if.sv | 21 ++
 rtl/ascon_wb_slave.sv | 124 ++++++++++++
 tb/tb_ascon_wb_slave.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_wb_if.sv
// Wishbone classic bus bundle between the host and the ASCON host-side slave.
interface ascon_wb_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ascon_wb_slave.sv
// Wishbone slave for the ASCON data memory window plus CTRL/DATALEN/STATUS registers.
module ascon_wb_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             nRST,
  ascon_wb_if.slave        wb,
  input  logic [31:0]      mem_dataout,
  input  logic             core_done,
  output logic             wb_we,
  output logic [4:0]       wb_addr,
  output logic [31:0]      datain_wb,
  output logic             busy,
  output logic [6:0]       datalen,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, XFER, RDCAP, ACK} state_t;

  state_t      state, state_nxt;
  logic [7:0]  r_off;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic        done;
  logic        irq_en;

  logic        req;
  logic        is_mem;
  logic        reg_wr;
  logic        ctrl_wr, dlen_wr, stat_wr;

  assign req     = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign is_mem  = ~r_off[7];
  assign reg_wr  = (state == XFER) & r_we & r_off[7] & r_sel[0];
  assign ctrl_wr = reg_wr & (r_off[6:2] == 5'd0);
  assign dlen_wr = reg_wr & (r_off[6:2] == 5'd1);
  assign stat_wr = reg_wr & (r_off[6:2] == 5'd2);
  assign irq     = done & irq_en;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    wb_we         = 1'b0;
    wb.wbs_ack_o  = 1'b0;
    unique case (state)
      IDLE:  if (req) state_nxt = XFER;
      XFER: begin
        state_nxt = (is_mem & ~r_we) ? RDCAP : ACK;
        wb_we     = r_we & is_mem & (r_sel == 4'hF) & ~busy;
      end
      RDCAP: state_nxt = ACK;
      ACK: begin
        state_nxt    = IDLE;
        wb.wbs_ack_o = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port is only retargeted by memory accesses so it holds across register traffic.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_off     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_dat     <= '0;
      wb_addr   <= '0;
      datain_wb <= '0;
    end else if (state == IDLE && req) begin
      r_off <= wb.wbs_adr_i[7:0];
      r_we  <= wb.wbs_we_i;
      r_sel <= wb.wbs_sel_i;
      r_dat <= wb.wbs_dat_i;
      if (!wb.wbs_adr_i[7]) begin
        wb_addr   <= wb.wbs_adr_i[6:2];
        datain_wb <= wb.wbs_dat_i;
      end
    end
  end

  // Later assignments win: abort over start, core_done set over STATUS clear.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      irq_en  <= 1'b0;
      datalen <= '0;
    end else begin
      if (ctrl_wr) irq_en <= r_dat[1];
      if (dlen_wr && !busy) datalen <= r_dat[6:0];
      if (stat_wr && r_dat[1]) done <= 1'b0;
      if (ctrl_wr && r_dat[2]) begin
        busy <= 1'b0;
      end else if (ctrl_wr && r_dat[0] && !busy) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (core_done && busy) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wb.wbs_dat_o <= '0;
    end else if (state == XFER && !r_we && r_off[7]) begin
      unique case (r_off[6:2])
        5'd0:    wb.wbs_dat_o <= {30'd0, irq_en, 1'b0};
        5'd1:    wb.wbs_dat_o <= {25'd0, datalen};
        5'd2:    wb.wbs_dat_o <= {30'd0, done, busy};
        default: wb.wbs_dat_o <= '0;
      endcase
    end else if (state == RDCAP) begin
      wb.wbs_dat_o <= busy ? '0 : mem_dataout;
    end
  end

endmodule

// File: tb/tb_ascon_wb_slave.sv
// Randomized self-checking bench for ascon_wb_slave against a register/memory reference model.
module tb_ascon_wb_slave;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  ascon_wb_if bus ();
  logic [31:0] mem_dataout;
  logic        core_done;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] datain_wb;
  logic        busy;
  logic [6:0]  datalen;
  logic        irq;

  ascon_wb_slave #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .wb          (bus),
    .mem_dataout (mem_dataout),
    .core_done   (core_done),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .datain_wb   (datain_wb),
    .busy        (busy),
    .datalen     (datalen),
    .irq         (irq)
  );

  // Environment memory: synchronous write, one-cycle read latency.
  logic [31:0] tb_mem [32];
  always @(posedge clk) begin
    if (wb_we) tb_mem[wb_addr] <= datain_wb;
    mem_dataout <= tb_mem[wb_addr];
  end

  logic [31:0] ref_mem [32];
  bit          m_busy, m_done, m_irq_en;
  logic [6:0]  m_dlen;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(m_busy));
    check({tag, "_irq"}, 32'(irq), 32'(m_done & m_irq_en));
    check({tag, "_dlen"}, 32'(datalen), 32'(m_dlen));
  endtask

  task automatic bus_xact(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit pd,
                          output logic [31:0] rdat, output int lat, output int we_cnt,
                          output logic [4:0] we_addr, output logic [31:0] we_data);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    lat = 0; we_cnt = 0; rdat = '0; we_addr = '0; we_data = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      core_done = pd && (i == 1);
      if (wb_we) begin
        we_cnt++;
        we_addr = wb_addr;
        we_data = datain_wb;
      end
      if (bus.wbs_ack_o) begin
        lat  = i;
        rdat = bus.wbs_dat_o;
        break;
      end
    end
    core_done     = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel, input bit pd);
    logic [31:0] unused_rd, wdat;
    logic [4:0]  wa;
    int          lat, wc;
    bit          qual, b0;
    qual = !off[7] && sel == 4'hF && !m_busy;
    b0   = m_busy;
    bus_xact(1'b1, BASE | 32'(off), d, sel, pd, unused_rd, lat, wc, wa, wdat);
    check("wr_lat", lat, 2);
    check("wr_we_cnt", wc, qual ? 1 : 0);
    if (qual) begin
      check("wr_addr", 32'(wa), 32'(off[6:2]));
      check("wr_data", wdat, d);
      ref_mem[off[6:2]] = d;
    end
    if (off[7] && sel[0]) begin
      case (off)
        8'h80: begin
          m_irq_en = d[1];
          if (d[2]) m_busy = 1'b0;
          else if (d[0] && !m_busy) begin m_busy = 1'b1; m_done = 1'b0; end
        end
        8'h84: if (!m_busy) m_dlen = d[6:0];
        8'h88: if (d[1]) m_done = 1'b0;
        default: ;
      endcase
    end
    if (pd && b0) begin m_busy = 1'b0; m_done = 1'b1; end
    chk_outs("wr");
  endtask

  task automatic rd(input logic [7:0] off);
    logic [31:0] got, exp, wdat;
    logic [4:0]  wa;
    int          lat, wc, exp_lat;
    if (!off[7]) begin
      exp     = m_busy ? 32'd0 : ref_mem[off[6:2]];
      exp_lat = 3;
    end else begin
      exp_lat = 2;
      case (off)
        8'h80:   exp = {30'd0, m_irq_en, 1'b0};
        8'h84:   exp = {25'd0, m_dlen};
        8'h88:   exp = {30'd0, m_done, m_busy};
        default: exp = 32'd0;
      endcase
    end
    bus_xact(1'b0, BASE | 32'(off), $urandom, 4'hF, 1'b0, got, lat, wc, wa, wdat);
    check("rd_lat", lat, exp_lat);
    check("rd_we_cnt", wc, 0);
    check($sformatf("rd_data_%02h", off), got, exp);
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    if (m_busy) begin m_busy = 1'b0; m_done = 1'b1; end
    chk_outs("pulse");
  endtask

  initial begin
    int acks, wes;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    core_done     = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_irq_en = 1'b0; m_dlen = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.wbs_ack_o), 32'(0));
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    check("rst_we", 32'(wb_we), 32'(0));
    check("rst_addr", 32'(wb_addr), 32'(0));
    check("rst_din", datain_wb, 32'd0);
    chk_outs("rst");
    nRST = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) wr(8'(i * 4), $urandom, 4'hF, 1'b0);

    wr(8'h14, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd(8'h14);

    wr(8'h84, 32'h2B, 4'hF, 1'b0);
    wr(8'h80, 32'h3, 4'hF, 1'b0);
    rd(8'h84);
    wr(8'h84, 32'h10, 4'hF, 1'b0);
    rd(8'h84);
    wr(8'h18, 32'h1234_5678, 4'hF, 1'b0);
    rd(8'h18);
    pulse_done();
    rd(8'h88);
    wr(8'h88, 32'h2, 4'hF, 1'b0);
    rd(8'h88);

    wr(8'h80, 32'h3, 4'hF, 1'b0);
    wr(8'h88, 32'h2, 4'hF, 1'b1);
    rd(8'h88);

    wr(8'h80, 32'h1, 4'hF, 1'b0);
    wr(8'h80, 32'h4, 4'hF, 1'b0);
    rd(8'h88);
    wr(8'h80, 32'h5, 4'hF, 1'b0);
    rd(8'h88);

    rd(8'h90);
    wr(8'h90, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr(8'h20, 32'hCAFE_F00D, 4'h3, 1'b0);
    rd(8'h20);
    wr(8'h80, 32'h2, 4'hE, 1'b0);
    rd(8'h80);

    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: wr(8'($urandom_range(0, 31) * 4), $urandom,
                       ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, 1'b0);
        4, 5, 6:    rd(8'($urandom_range(0, 31) * 4));
        7:          wr(8'h84, $urandom, 4'($urandom), 1'b0);
        8:          wr(8'h80, 32'($urandom_range(0, 7)), 4'($urandom), 1'b0);
        default: begin
          if ($urandom_range(0, 1) == 1) pulse_done();
          else wr(8'h88, 32'h2, 4'hF, ($urandom_range(0, 1) == 1));
          rd(8'($urandom_range(0, 3) * 4 + 8'h80));
        end
      endcase
    end

    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3000_0100;
    bus.wbs_dat_i = 32'h5555_AAAA;
    acks = 0; wes = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
      if (wb_we) wes++;
    end
    check("oow_ack", acks, 0);
    check("oow_we", wes, 0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(posedge clk); #1;

    wr(8'h80, 32'h4, 4'hF, 1'b0);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE | 32'h0C;
    bus.wbs_dat_i = ~ref_mem[3];
    @(posedge clk); #1;
    check("xfer_we", 32'(wb_we), 32'(1));
    nRST = 1'b0;
    #1;
    check("mid_ack", 32'(bus.wbs_ack_o), 32'(0));
    check("mid_we", 32'(wb_we), 32'(0));
    check("mid_addr", 32'(wb_addr), 32'(0));
    check("mid_din", datain_wb, 32'd0);
    check("mid_dat", bus.wbs_dat_o, 32'd0);
    m_busy = 1'b0; m_done = 1'b0; m_irq_en = 1'b0; m_dlen = '0;
    chk_outs("mid");
    @(posedge clk); #1;
    check("mid_ack2", 32'(bus.wbs_ack_o), 32'(0));
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
    nRST = 1'b1;
    @(posedge clk); #1;
    rd(8'h0C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
